// File: rtl/led_pkg.sv
// Shared LED sequencer definitions: mode codes, FSM states, initial frames and frame stepping.
// Pure declarations and functions; no latency or flow control of their own.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_FILL_DOWN = 2'd0,
    MODE_FILL_UP   = 2'd1,
    MODE_DOT_RUN   = 2'd2,
    MODE_BLINK     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [LED_W-1:0] INIT_FILL_DOWN = 8'h00;
  localparam logic [LED_W-1:0] INIT_FILL_UP   = 8'h00;
  localparam logic [LED_W-1:0] INIT_DOT_RUN   = 8'h80;
  localparam logic [LED_W-1:0] INIT_BLINK     = 8'h00;
  localparam logic [LED_W-1:0] LED_ALL        = {LED_W{1'b1}};

  function automatic logic [LED_W-1:0] init_frame(input mode_e m);
    logic [LED_W-1:0] f;
    case (m)
      MODE_FILL_DOWN: f = INIT_FILL_DOWN;
      MODE_FILL_UP:   f = INIT_FILL_UP;
      MODE_DOT_RUN:   f = INIT_DOT_RUN;
      default:        f = INIT_BLINK;
    endcase
    return f;
  endfunction

  // The frame whose next step wraps back to the initial frame, i.e. completes a cycle.
  function automatic logic is_last_frame(input mode_e m, input logic [LED_W-1:0] f);
    return (m == MODE_DOT_RUN) ? (f == LED_W'(1)) : (f == LED_ALL);
  endfunction

  function automatic logic [LED_W-1:0] next_frame(input mode_e m, input logic [LED_W-1:0] f);
    logic [LED_W-1:0] nxt;
    case (m)
      MODE_FILL_DOWN: nxt = {1'b1, f[LED_W-1:1]};
      MODE_FILL_UP:   nxt = {f[LED_W-2:0], 1'b1};
      MODE_DOT_RUN:   nxt = f >> 1;
      default:        nxt = ~f;
    endcase
    if (is_last_frame(m, f)) nxt = init_frame(m);
    return nxt;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control and LED-drive bundle of the pattern sequencer; master = board controls, slave = sequencer.
// Plain wires, no latency; single-cycle request pulses with no backpressure.
interface led_pattern_sequencer_if;

  logic                      start;
  logic                      stop;
  logic [1:0]                mode_sel;
  logic                      auto_mode;
  logic [led_pkg::LED_W-1:0] led;
  logic                      busy;
  logic [1:0]                cur_mode;
  logic                      cycle_done;

  modport master (
    output start, stop, mode_sel, auto_mode,
    input  led, busy, cur_mode, cycle_done
  );

  modport slave (
    input  start, stop, mode_sel, auto_mode,
    output led, busy, cur_mode, cycle_done
  );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: one tick every TICK_DIV enabled clocks, synchronous clear has priority over enable.
// tick is combinational from the count (asserted in the last count cycle); no backpressure.
module led_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 8-LED pattern sequencer: IDLE/RUN FSM, prescaled frame stepping, cycle counting, optional auto-advance.
// start/stop take effect on the next edge, first step TICK_DIV clocks later; requests are never stalled.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int REPEAT   = 2
) (
  input logic                    clk,
  input logic                    reset,
  led_pattern_sequencer_if.slave seq
);

  localparam int               RPT_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, mode_inc;
  logic [LED_W-1:0] led_q, led_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             done_q, done_d;
  logic             tick;

  assign mode_inc = mode_e'(mode_q + 2'd1);

  // Any start or stop request restarts the step interval from zero.
  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .clr   (seq.start || seq.stop),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;
    if (seq.stop) begin
      state_d = ST_IDLE;
      led_d   = '0;
      rpt_d   = '0;
    end else if (seq.start) begin
      state_d = ST_RUN;
      mode_d  = mode_e'(seq.mode_sel);
      led_d   = init_frame(mode_e'(seq.mode_sel));
      rpt_d   = '0;
    end else if (tick) begin
      led_d = next_frame(mode_q, led_q);
      if (is_last_frame(mode_q, led_q)) begin
        done_d = 1'b1;
        if (rpt_q == RPT_LAST) begin
          rpt_d = '0;
          if (seq.auto_mode) begin
            mode_d = mode_inc;
            led_d  = init_frame(mode_inc);
          end
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FILL_DOWN;
      led_q   <= '0;
      rpt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      rpt_q   <= rpt_d;
      done_q  <= done_d;
    end
  end

  assign seq.led        = led_q;
  assign seq.busy       = (state_q == ST_RUN);
  assign seq.cur_mode   = mode_q;
  assign seq.cycle_done = done_q;

endmodule
